// File: rtl/cache_ctrl_2way_wb.sv
// cache_ctrl_2way_wb: 2-way set-associative, write-back, write-allocate data
// cache controller with true LRU per set. It serves a single-word CPU
// load/store port and moves whole 128-bit blocks to and from memory.
// Optional build macro CACHE_STATS_EN adds saturating HitCount/MissCount outputs.
module cache_ctrl_2way_wb #(
    parameter int SET_BITS = 1,
    parameter int MEM_LAT  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         CpuReq,
    input  logic         CpuWe,
    input  logic [9:0]   CpuAddr,
    input  logic [31:0]  CpuWData,
    output logic [31:0]  CpuRData,
    output logic         CpuReady,
    output logic         MemReadOrWrite,
    output logic [9:0]   MemAddr,
    output logic [127:0] MemWriteData,
    input  logic [127:0] MemReadData
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]  HitCount,
    output logic [15:0]  MissCount
`endif
);
    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = 6 - SET_BITS;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    // Control state
    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                req_we_q,    req_we_d;
    logic [9:2]          req_addr_q,  req_addr_d;
    logic [31:0]         req_wdata_q, req_wdata_d;
    logic                victim_q,    victim_d;

    // Per-line status bits, indexed [set][way]
    logic [SETS-1:0][1:0] valid_q, valid_d;
    logic [SETS-1:0][1:0] dirty_q, dirty_d;
    // LRU[set] names the way to evict next
    logic [SETS-1:0]      lru_q,   lru_d;

    // Registered outputs
    logic         cpu_ready_q, cpu_ready_d;
    logic [31:0]  cpu_rdata_q, cpu_rdata_d;
    logic         mem_we_q,    mem_we_d;
    logic [9:0]   mem_addr_q,  mem_addr_d;
    logic [127:0] mem_wdata_q, mem_wdata_d;

    // Tag and data arrays, indexed [way][set]
    logic [TAG_W-1:0] tag_q  [2][SETS];
    logic [127:0]     data_q [2][SETS];

    // Array write port
    logic         line_we;
    logic         line_way;
    logic [127:0] line_wdata;
    logic         tag_we;

    // Request decode
    logic [1:0]          req_word;
    logic [SET_BITS-1:0] req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                hit0, hit1, hit, hit_way, victim_way;
    logic [127:0]        sel_line, merged_line;

    // Byte-offset bits carry no information for word accesses
    logic unused_addr_bits;
    assign unused_addr_bits = ^CpuAddr[1:0];

    assign req_word = req_addr_q[3:2];
    assign req_idx  = req_addr_q[4 +: SET_BITS];
    assign req_tag  = req_addr_q[9 -: TAG_W];

    assign hit0    = valid_q[req_idx][0] && (tag_q[0][req_idx] == req_tag);
    assign hit1    = valid_q[req_idx][1] && (tag_q[1][req_idx] == req_tag);
    assign hit     = hit0 || hit1;
    assign hit_way = !hit0;

    // Prefer an empty way (way0 first); otherwise evict the LRU way
    assign victim_way = !valid_q[req_idx][0] ? 1'b0 :
                        !valid_q[req_idx][1] ? 1'b1 : lru_q[req_idx];

    assign CpuReady       = cpu_ready_q;
    assign CpuRData       = cpu_rdata_q;
    assign MemReadOrWrite = mem_we_q;
    assign MemAddr        = mem_addr_q;
    assign MemWriteData   = mem_wdata_q;

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q,  hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    // Set while the pending COMPARE is the re-check after a fill
    logic        refill_q,   refill_d;

    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;
`endif

    // Next-state, status-bit and output computation
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; that is what keeps this block from inferring latches.
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        victim_d    = victim_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        lru_d       = lru_q;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        line_we     = 1'b0;
        line_way    = 1'b0;
        line_wdata  = '0;
        tag_we      = 1'b0;
`ifdef CACHE_STATS_EN
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        refill_d    = refill_q;
`endif

        // NOTE: blocking assignments here are intentional: later statements
        // see the values just computed (e.g. the merged line below).
        sel_line    = data_q[hit_way][req_idx];
        merged_line = sel_line;
        merged_line[127 - 32*int'(req_word) -: 32] = req_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (CpuReq) begin
                    req_we_d    = CpuWe;
                    req_addr_d  = CpuAddr[9:2];
                    req_wdata_d = CpuWData;
                    state_d     = S_COMPARE;
`ifdef CACHE_STATS_EN
                    refill_d    = 1'b0;
`endif
                end
            end

            S_COMPARE: begin
                if (hit) begin
                    cpu_ready_d = 1'b1;
                    if (req_we_q) begin
                        line_we    = 1'b1;
                        line_way   = hit_way;
                        line_wdata = merged_line;
                        dirty_d[req_idx][hit_way] = 1'b1;
                    end else begin
                        cpu_rdata_d = sel_line[127 - 32*int'(req_word) -: 32];
                    end
                    lru_d[req_idx] = !hit_way;
                    state_d        = S_IDLE;
`ifdef CACHE_STATS_EN
                    if (!refill_q && hit_cnt_q != 16'hFFFF)
                        hit_cnt_d = hit_cnt_q + 16'd1;
`endif
                end else begin
                    victim_d = victim_way;
                    cnt_d    = '0;
                    if (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[victim_way][req_idx], req_idx, 4'b0000};
                        mem_wdata_d = data_q[victim_way][req_idx];
                        state_d     = S_WRITEBACK;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {req_tag, req_idx, 4'b0000};
                        state_d     = S_ALLOCATE;
                    end
`ifdef CACHE_STATS_EN
                    if (miss_cnt_q != 16'hFFFF)
                        miss_cnt_d = miss_cnt_q + 16'd1;
`endif
                end
            end

            S_WRITEBACK: begin
                if (cnt_q == CNT_LAST) begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = {req_tag, req_idx, 4'b0000};
                    dirty_d[req_idx][victim_q] = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_ALLOCATE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_ALLOCATE: begin
                if (cnt_q == CNT_LAST) begin
                    line_we    = 1'b1;
                    line_way   = victim_q;
                    line_wdata = MemReadData;
                    tag_we     = 1'b1;
                    valid_d[req_idx][victim_q] = 1'b1;
                    dirty_d[req_idx][victim_q] = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_COMPARE;
`ifdef CACHE_STATS_EN
                    refill_d   = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Control, status and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            victim_q    <= 1'b0;
            valid_q     <= '0;
            dirty_q     <= '0;
            lru_q       <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            victim_q    <= victim_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            lru_q       <= lru_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Tag/data array writes
    // NOTE: the arrays carry no reset; clearing the valid bits is enough to
    // make their contents unreachable, and it lets them map onto plain RAM.
    always_ff @(posedge clk) begin
        if (line_we)
            data_q[line_way][req_idx] <= line_wdata;
        if (tag_we)
            tag_q[line_way][req_idx] <= req_tag;
    end

`ifdef CACHE_STATS_EN
    // Saturating hit/miss counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            refill_q   <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            refill_q   <= refill_d;
        end
    end
`endif

endmodule
